pc_sequencer: RTL and testbench

- Upstream control stage for the program-byte fetch register.
- Owns the 12-bit program counter, drives the program ROM address, and generates the `phase` enable that makes the fetch register capture `{instr, operand}`.
- Consumes the captured opcode and operand to sequence single-byte instructions, two-byte conditional jumps and halt.

---
 rtl/nibbler_pkg.sv | 37 +++
 rtl/pc_sequencer_jump_cond.sv | 36 +++
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nibbler_pkg
//  Purpose  : Shared definitions for the nibbler control path. Holds the
//             opcode encodings, the sequencer state type and the jump-opcode
//             classifier.
//  Contents : OP_* opcode constants, seq_state_t, is_jump()
//  Revision : 1.0 - initial release
// ============================================================================
package nibbler_pkg;

   // Opcodes are the high nibble of a program byte.
   localparam logic [3:0] OP_JC   = 4'h0;
   localparam logic [3:0] OP_JNC  = 4'h1;
   localparam logic [3:0] OP_JZ   = 4'h2;
   localparam logic [3:0] OP_JNZ  = 4'h3;
   localparam logic [3:0] OP_HALT = 4'hE;
   localparam logic [3:0] OP_JMP  = 4'hF;

   // Sequencer states. Outputs are decoded directly from these.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      ADDR  = 3'd3,
      HALT  = 3'd4
   } seq_state_t;

   // True for every two-byte instruction (the four conditional jumps and JMP).
   function automatic logic is_jump(input logic [3:0] opcode);
      return (opcode == OP_JC)  || (opcode == OP_JNC) ||
             (opcode == OP_JZ)  || (opcode == OP_JNZ) ||
             (opcode == OP_JMP);
   endfunction

endpackage : nibbler_pkg
`default_nettype wire

// File: rtl/pc_sequencer_jump_cond.sv
`default_nettype none
// ============================================================================
//  Module   : jump_cond
//  Purpose  : Combinational branch-condition evaluator. Decides whether a
//             jump opcode is taken given the current ALU flags. Non-jump
//             opcodes never report taken, so a monitor may feed it any
//             opcode without pre-filtering.
//  Ports    : opcode [3:0] in  - opcode under evaluation
//             carry        in  - ALU carry flag
//             zero         in  - ALU zero flag
//             take         out - 1 when the jump is taken
//  Revision : 1.0 - initial release
// ============================================================================
module jump_cond
   import nibbler_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       carry,
   input  logic       zero,
   output logic       take
);

   always_comb begin
      take = 1'b0;
      unique case (opcode)
         OP_JC   : take = carry;
         OP_JNC  : take = ~carry;
         OP_JZ   : take = zero;
         OP_JNZ  : take = ~zero;
         OP_JMP  : take = 1'b1;
         default : take = 1'b0;
      endcase
   end

endmodule : jump_cond
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Upstream control stage for the program-byte fetch register.
//             Owns the program counter, drives the ROM address, pulses the
//             fetch-register enable (phase) and sequences single-byte
//             instructions, two-byte conditional jumps and halt.
//  Ports    : clk                   in  - system clock, rising edge
//             reset                 in  - asynchronous, active-low reset
//             run                   in  - start/continue enable
//             instr [3:0]           in  - captured opcode (valid in EXEC/ADDR)
//             operand [3:0]         in  - captured operand, jump target high
//             program_byte [7:0]    in  - ROM data at address
//             carry, zero           in  - ALU flags, sampled at end of ADDR
//             address [ADDR_W-1:0]  out - ROM address (the PC register)
//             phase                 out - fetch-register enable (FETCH only)
//             halted                out - 1 while halted
//             jump_taken            out - 1-cycle pulse at the jump target
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
   import nibbler_pkg::*;
#(
   parameter int                 ADDR_W   = 12,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [3:0]        instr,
   input  logic [3:0]        operand,
   input  logic [7:0]        program_byte,
   input  logic              carry,
   input  logic              zero,
   output logic [ADDR_W-1:0] address,
   output logic              phase,
   output logic              halted,
   output logic              jump_taken
);

   seq_state_t        r_state;
   seq_state_t        w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_target;
   logic              r_jump_taken;
   logic              w_jump_taken_nxt;
   logic              w_take;

   // Opcode stays valid through ADDR because the fetch register only loads
   // while phase is high, so the condition can be evaluated from instr there.
   jump_cond u_jump_cond (
      .opcode (instr),
      .carry  (carry),
      .zero   (zero),
      .take   (w_take)
   );

   // Natural-width add: wraps modulo 2^ADDR_W, so the last address rolls to 0.
   assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

   // Jump target: operand supplies the high nibble, the second program byte
   // (read combinationally at the current PC during ADDR) the low byte.
   assign w_target = ADDR_W'({operand, program_byte});

   // ------------------------------------------------------------------------
   // State, PC and jump pulse registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_jump_taken <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_jump_taken <= w_jump_taken_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / next-PC logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_jump_taken_nxt = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (run) begin
               w_state_nxt = FETCH;
            end
         end

         FETCH: begin
            // The fetch register captures program_byte on this closing edge.
            w_state_nxt = EXEC;
         end

         EXEC: begin
            if (is_jump(instr)) begin
               // Step onto the low target byte; it is read during ADDR.
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = ADDR;
            end else if (instr == OP_HALT) begin
               w_state_nxt = HALT;
            end else begin
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = run ? FETCH : IDLE;
            end
         end

         ADDR: begin
            if (w_take) begin
               w_pc_nxt         = w_target;
               w_jump_taken_nxt = 1'b1;
            end else begin
               w_pc_nxt         = w_pc_inc;
            end
            w_state_nxt = FETCH;
         end

         HALT: begin
            // Only reset leaves HALT; run is deliberately ignored.
            w_state_nxt = HALT;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs decoded from registered state only
   // ------------------------------------------------------------------------
   assign address    = r_pc;
   assign phase      = (r_state == FETCH);
   assign halted     = (r_state == HALT);
   assign jump_taken = r_jump_taken;

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer. Models the program ROM and
//             the downstream fetch register, drives run/flags per cycle and
//             compares address/phase/halted/jump_taken against hand-derived
//             expectations queued at drive time.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        run = 1'b0;
   logic [3:0]  instr = 4'h0;
   logic [3:0]  operand = 4'h0;
   logic [7:0]  program_byte;
   logic        carry = 1'b0;
   logic        zero = 1'b0;
   logic [11:0] address;
   logic        phase;
   logic        halted;
   logic        jump_taken;

   logic [7:0]  rom [4096];

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [11:0] addr;
      logic        ph;
      logic        h;
      logic        jt;
      string       name;
   } exp_t;

   exp_t sb[$];

   // One-cycle vector: inputs for this cycle plus outputs expected in it.
   typedef struct {
      logic        run;
      logic        c;
      logic        z;
      logic [11:0] addr;
      logic        ph;
      logic        jt;
   } vec_t;

   // Jump case: two program bytes at 0x000/0x001, flags in ADDR, outcome.
   typedef struct {
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic        c;
      logic        z;
      logic        taken;
      logic [11:0] target;
      string       name;
   } jvec_t;

   always #5 clk = ~clk;

   assign program_byte = rom[address];

   // Downstream fetch register.
   always @(posedge clk) begin
      if (phase) begin
         instr   <= program_byte[7:4];
         operand <= program_byte[3:0];
      end
   end

   pc_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .run          (run),
      .instr        (instr),
      .operand      (operand),
      .program_byte (program_byte),
      .carry        (carry),
      .zero         (zero),
      .address      (address),
      .phase        (phase),
      .halted       (halted),
      .jump_taken   (jump_taken)
   );

   task automatic rom_fill();
      // 0x90: opcode 9, an ordinary single-byte instruction.
      for (int i = 0; i < 4096; i++) rom[i] = 8'h90;
   endtask

   // Queue an expectation and compare it against the outputs right now.
   task automatic expect_now(input logic [11:0] a, input logic p, input logic h,
                             input logic j, input string name);
      exp_t e;
      sb.push_back('{addr: a, ph: p, h: h, jt: j, name: name});
      e = sb.pop_front();
      n_vec++;
      if (address !== e.addr || phase !== e.ph || halted !== e.h || jump_taken !== e.jt) begin
         n_fail++;
         $display("FAIL %s: got addr=%h phase=%b halted=%b jump_taken=%b, want addr=%h phase=%b halted=%b jump_taken=%b",
                  e.name, address, phase, halted, jump_taken, e.addr, e.ph, e.h, e.jt);
      end
   endtask

   // Drive inputs at the falling edge, then check the outputs of this cycle.
   task automatic cyc(input logic r, input logic c, input logic z,
                      input logic [11:0] a, input logic p, input logic h,
                      input logic j, input string name);
      @(negedge clk);
      run   = r;
      carry = c;
      zero  = z;
      #1;
      expect_now(a, p, h, j, name);
   endtask

   task automatic do_reset();
      @(negedge clk);
      run   = 1'b0;
      carry = 1'b0;
      zero  = 1'b0;
      reset = 1'b0;
      #1;
      expect_now(12'h000, 1'b0, 1'b0, 1'b0, "reset_state");
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   vec_t  seq1 [9];
   jvec_t jt_tab [11];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Two non-jump bytes then a run=0 drop back to IDLE.
      seq1[0] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
      seq1[1] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
      seq1[2] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};
      seq1[3] = '{1'b1, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0};
      seq1[4] = '{1'b1, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0};
      seq1[5] = '{1'b1, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0};
      seq1[6] = '{1'b0, 1'b0, 1'b0, 12'h002, 1'b0, 1'b0};
      seq1[7] = '{1'b0, 1'b0, 1'b0, 12'h003, 1'b0, 1'b0};
      seq1[8] = '{1'b0, 1'b0, 1'b0, 12'h003, 1'b0, 1'b0};

      jt_tab[0]  = '{8'hF3, 8'h7C, 1'b0, 1'b0, 1'b1, 12'h37C, "jmp"};
      jt_tab[1]  = '{8'h23, 8'h7C, 1'b0, 1'b0, 1'b0, 12'h002, "jz_z0"};
      jt_tab[2]  = '{8'h23, 8'h7C, 1'b0, 1'b1, 1'b1, 12'h37C, "jz_z1"};
      jt_tab[3]  = '{8'h03, 8'h7C, 1'b1, 1'b0, 1'b1, 12'h37C, "jc_c1"};
      jt_tab[4]  = '{8'h03, 8'h7C, 1'b0, 1'b1, 1'b0, 12'h002, "jc_c0"};
      jt_tab[5]  = '{8'h13, 8'h7C, 1'b0, 1'b0, 1'b1, 12'h37C, "jnc_c0"};
      jt_tab[6]  = '{8'h13, 8'h7C, 1'b1, 1'b0, 1'b0, 12'h002, "jnc_c1"};
      jt_tab[7]  = '{8'h33, 8'h7C, 1'b1, 1'b0, 1'b1, 12'h37C, "jnz_z0"};
      jt_tab[8]  = '{8'h33, 8'h7C, 1'b0, 1'b1, 1'b0, 12'h002, "jnz_z1"};
      jt_tab[9]  = '{8'hF3, 8'h7C, 1'b1, 1'b1, 1'b1, 12'h37C, "jmp_flags"};
      jt_tab[10] = '{8'hFA, 8'h01, 1'b0, 1'b0, 1'b1, 12'hA01, "jmp_a01"};

      // ---- Sequence of single-byte instructions ------------------------------
      rom_fill();
      rom[0] = 8'h4A;
      rom[1] = 8'h51;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cyc(seq1[i].run, seq1[i].c, seq1[i].z, seq1[i].addr, seq1[i].ph, 1'b0,
             seq1[i].jt, $sformatf("seq1_c%0d", i));
         if (i == 3 && (instr !== 4'h4 || operand !== 4'hA)) begin
            n_fail++;
            $display("FAIL seq1_fetch0: got %h/%h, want 4/a", instr, operand);
         end
         if (i == 5 && (instr !== 4'h5 || operand !== 4'h1)) begin
            n_fail++;
            $display("FAIL seq1_fetch1: got %h/%h, want 5/1", instr, operand);
         end
      end

      // ---- Jump opcode / flag table --------------------------------------------
      for (int k = 0; k < 11; k++) begin
         rom_fill();
         rom[0] = jt_tab[k].b0;
         rom[1] = jt_tab[k].b1;
         do_reset();
         cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, {jt_tab[k].name, "_idle"});
         cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, {jt_tab[k].name, "_fetch"});
         cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, {jt_tab[k].name, "_exec"});
         cyc(1'b1, jt_tab[k].c, jt_tab[k].z, 12'h001, 1'b0, 1'b0, 1'b0, {jt_tab[k].name, "_addr"});
         cyc(1'b1, 1'b0, 1'b0, jt_tab[k].target, 1'b1, 1'b0, jt_tab[k].taken, {jt_tab[k].name, "_next"});
         cyc(1'b1, 1'b0, 1'b0, jt_tab[k].target, 1'b0, 1'b0, 1'b0, {jt_tab[k].name, "_after"});
      end

      // ---- PC wrap after a non-jump at 0xFFF -----------------------------------
      rom_fill();
      rom[0]     = 8'hFF;
      rom[1]     = 8'hFF;
      rom[12'hFFF] = 8'h41;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "wrap_idle");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "wrap_fetch");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "wrap_exec");
      cyc(1'b1, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, "wrap_addr");
      cyc(1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b1, "wrap_fff_fetch");
      cyc(1'b1, 1'b0, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0, "wrap_fff_exec");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "wrap_000_fetch");

      // ---- Jump at 0xFFF takes its low byte from 0x000 -------------------------
      rom[12'hFFF] = 8'hF2;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "wrapj_idle");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "wrapj_fetch");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "wrapj_exec");
      cyc(1'b1, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, "wrapj_addr");
      cyc(1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b1, "wrapj_fff_fetch");
      cyc(1'b1, 1'b0, 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0, "wrapj_fff_exec");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "wrapj_000_addr");
      cyc(1'b1, 1'b0, 1'b0, 12'h2FF, 1'b1, 1'b0, 1'b1, "wrapj_2ff_fetch");

      // ---- HALT at 0x005, then asynchronous reset out of it --------------------
      rom_fill();
      rom[5] = 8'hE0;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "halt_idle");
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 12'(i), 1'b1, 1'b0, 1'b0, $sformatf("halt_fetch%0d", i));
         cyc(1'b1, 1'b0, 1'b0, 12'(i), 1'b0, 1'b0, 1'b0, $sformatf("halt_exec%0d", i));
      end
      for (int i = 0; i < 20; i++) begin
         cyc(i[0], 1'b0, 1'b0, 12'h005, 1'b0, 1'b1, 1'b0, $sformatf("halted_%0d", i));
      end
      @(negedge clk);
      #2;
      run   = 1'b0;
      reset = 1'b0;
      #1;
      expect_now(12'h000, 1'b0, 1'b0, 1'b0, "halt_async_reset");
      @(negedge clk);
      reset = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "post_halt_idle");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "post_halt_fetch");

      // ---- Reset during ADDR aborts the jump ----------------------------------
      rom_fill();
      rom[0] = 8'hF3;
      rom[1] = 8'h7C;
      do_reset();
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "midj_idle");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "midj_fetch");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "midj_exec");
      cyc(1'b0, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, "midj_addr");
      reset = 1'b0;
      #1;
      expect_now(12'h000, 1'b0, 1'b0, 1'b0, "midj_reset");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, $sformatf("midj_post%0d", i));
      end
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, "midj_run");
      cyc(1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, "midj_refetch");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_pc_sequencer
`default_nettype wire
